spike_conv_pe: RTL and testbench
================================

SPIKE_CONV_PE -- requirements
Module: spike_conv_pe

Interface
REQ-001 SHALL have parameter PKT_W, default 64, packet width.
REQ-002 SHALL have parameter ADDR_W, default 4, destination/source address field width.
REQ-003 SHALL have parameter IFMAP_LEN, default 25, spike bits per ifmap row.
REQ-004 SHALL have parameter K, default 5, filter taps per row.
REQ-005 SHALL have parameter WEIGHT_W, default 8, unsigned weight width.
REQ-006 SHALL have parameter ACC_W, default 13, partial-sum width.
REQ-007 SHALL have parameter SRC_ADDR, default 0, own address placed in the source field.
REQ-008 SHALL have parameter PSUM_DST, default 0, destination of partial-sum packets.
REQ-009 SHALL have parameter FWD_DST, default 0, destination of the forwarded ifmap.
REQ-010 SHALL have parameter FORWARD_EN, default 1, enables ifmap forwarding.
REQ-011 SHALL have port clk, input, 1, the single clock; all logic samples on the rising edge.
REQ-012 SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-013 SHALL have ports in_data (input, PKT_W), in_valid (input, 1) and in_ready (output, 1): the packet input channel.
REQ-014 SHALL have ports out_data (output, PKT_W), out_valid (output, 1) and out_ready (input, 1): the packet output channel.
REQ-015 SHALL have port busy, output, 1: high in any state other than IDLE.
REQ-016 SHALL have port drop_pulse, output, 1: one-cycle pulse per discarded packet.

Function
REQ-017 SHALL use packet fields dest = [PKT_W-1 -: ADDR_W], src = next ADDR_W bits, type = next 2 bits, payload = remaining low bits (P = PKT_W-2*ADDR_W-2, i.e. 54).
REQ-018 SHALL decode type as 00 ifmap, 01 filter, 10 residue, 11 psum.
REQ-019 SHALL fail elaboration unless IFMAP_LEN ≤ P, K*WEIGHT_W ≤ P, K ≤ IFMAP_LEN, ACC_W ≥ WEIGHT_W+clog2(K), and IDX_W+ACC_W ≤ P.
REQ-020 SHALL define N = IFMAP_LEN-K+1 outputs and IDX_W = clog2(N).
REQ-021 SHALL complete an input transfer on a cycle where in_valid && in_ready; in_ready is a registered state decode and not a function of in_valid.
REQ-022 SHALL complete an output transfer on a cycle where out_valid && out_ready; while out_valid is high and out_ready is low, out_data is held stable.
REQ-023 SHALL implement the FSM states IDLE, WAIT_FILT, MAC, EMIT and FWD.
REQ-024 SHALL assert in_ready in IDLE and WAIT_FILT only.
REQ-025 (IDLE, filter): SHALL load w[k] = payload[k*WEIGHT_W +: WEIGHT_W], set filt_valid, and stay in IDLE; a later filter replaces the weights.
REQ-026 (IDLE, ifmap): SHALL latch spikes = payload[IFMAP_LEN-1:0]; go to MAC with j=0, k=0, acc=0 if filt_valid, otherwise go to WAIT_FILT.
REQ-027 (IDLE/WAIT_FILT, type 10 or 11): SHALL discard the packet, pulse drop_pulse on the cycle after acceptance, and keep the state.
REQ-028 (WAIT_FILT, filter): SHALL load the weights, set filt_valid, and go to MAC.
REQ-029 (WAIT_FILT, ifmap): SHALL replace the latched spikes and stay in WAIT_FILT.
REQ-030 (MAC): SHALL perform one tap per cycle, acc += spikes[j+k] ? w[k] : 0, for k = 0..K-1, taking exactly K cycles, then go to EMIT.
REQ-031 (EMIT): SHALL drive out_valid with {PSUM_DST, SRC_ADDR, 2'b11, zero pad, j[IDX_W-1:0], acc[ACC_W-1:0]}, with acc in the low bits and the output index immediately above it.
REQ-032 (EMIT, on transfer): SHALL go to MAC with j+1, k=0, acc=0 if j < N-1; otherwise go to FWD if FORWARD_EN, else IDLE.
REQ-033 (FWD): SHALL drive {FWD_DST, SRC_ADDR, 2'b00, zero pad, spikes}, and on transfer go to IDLE.
REQ-034 SHALL keep the accumulator unsigned and non-saturating; the width check in REQ-019 guarantees no overflow.
REQ-035 SHALL give latency from ifmap acceptance (filter loaded, out_ready high) of K+1 cycles to the first out_valid; output j leaves K+1 cycles after output j-1.
REQ-036 SHALL retain the weights and filt_valid across ifmaps until reset.
REQ-037 SHALL hold out_valid low outside EMIT and FWD.

Reset
REQ-038 SHALL, on rst high at a clock edge, clear state to IDLE, filt_valid, weights, spikes, j, k and acc, regardless of the current state.
REQ-039 SHALL drive out_valid=0, out_data=0, busy=0 and drop_pulse=0 during reset; in_ready=1 from the first cycle after rst deasserts.
REQ-040 SHALL abandon an in-flight packet sequence on reset mid-operation; no packet is resumed.

Verification
REQ-041 Filter with all weights 1, ifmap all ones -> 21 psum packets, idx 0..20, each acc=5, then a forwarded ifmap 0x1FFFFFF with type 00.
REQ-042 Filter w=[1,2,3,4,5], ifmap bit0 only -> idx0 acc=1, others 0; ifmap bit24 only -> idx20 acc=5, others 0.
REQ-043 Ifmap sent before any filter -> no output, busy=1; filter then sent -> 21 correct psums; first out_valid K+1 cycles after the filter is accepted.
REQ-044 out_ready held low for 10 cycles in EMIT -> out_data stable, no lost or duplicated idx.
REQ-045 Type-10 packet in IDLE -> drop_pulse for one cycle, no output; rst asserted at idx 7 -> out_valid=0 next cycle, a new ifmap requires reloading the filter.

Source files
------------

// File: rtl/spike_conv_pe.sv
// Spiking 1-D conv PE: stores a K-tap filter, convolves an ifmap row, emits N psum packets plus an optional ifmap forward.
// Latency K+1 cycles per psum; out_data holds while out_ready is low, and in_ready drops for the whole MAC/EMIT/FWD sequence.
module spike_conv_pe #(
    parameter int PKT_W      = 64,
    parameter int ADDR_W     = 4,
    parameter int IFMAP_LEN  = 25,
    parameter int K          = 5,
    parameter int WEIGHT_W   = 8,
    parameter int ACC_W      = 13,
    parameter int SRC_ADDR   = 0,
    parameter int PSUM_DST   = 0,
    parameter int FWD_DST    = 0,
    parameter int FORWARD_EN = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PKT_W-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [PKT_W-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             drop_pulse
);
    localparam int P     = PKT_W - 2*ADDR_W - 2;
    localparam int N     = IFMAP_LEN - K + 1;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int K_W   = (K > 1) ? $clog2(K) : 1;
    localparam int SP_W  = $clog2(IFMAP_LEN + 1);

    if (IFMAP_LEN > P || K*WEIGHT_W > P || K > IFMAP_LEN ||
        ACC_W < WEIGHT_W + $clog2(K) || IDX_W + ACC_W > P) begin : g_param_check
        $error("spike_conv_pe: inconsistent parameter set");
    end

    typedef enum logic [2:0] {IDLE, WAIT_FILT, MAC, EMIT, FWD} state_t;

    state_t                 state;
    logic                   filt_valid;
    logic [WEIGHT_W-1:0]    w [K];
    logic [IFMAP_LEN-1:0]   spikes;
    logic [IDX_W-1:0]       j;
    logic [K_W-1:0]         k;
    logic [ACC_W-1:0]       acc;

    logic [1:0]             in_type;
    logic                   in_fire;
    logic                   out_fire;
    logic [SP_W-1:0]        tap_idx;
    logic [ACC_W-1:0]       acc_sum;
    logic [P-1:0]           psum_pl;
    logic [P-1:0]           fwd_pl;
    logic                   unused_in;

    assign in_type  = in_data[P+1:P];
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;
    // Address fields and payload bits beyond the weights/spikes are not consumed.
    assign unused_in = ^in_data;

    always_comb begin
        tap_idx = SP_W'(j) + SP_W'(k);
        acc_sum = acc + (spikes[tap_idx] ? ACC_W'(w[k]) : '0);
        psum_pl = P'(acc_sum) | (P'(j) << ACC_W);
        fwd_pl  = P'(spikes);
    end

    function automatic logic [PKT_W-1:0] make_pkt(input logic [ADDR_W-1:0] dst,
                                                  input logic [1:0]        typ,
                                                  input logic [P-1:0]      pl);
        return {dst, ADDR_W'(SRC_ADDR), typ, pl};
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            filt_valid <= 1'b0;
            for (int i = 0; i < K; i++) w[i] <= '0;
            spikes     <= '0;
            j          <= '0;
            k          <= '0;
            acc        <= '0;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            out_data   <= '0;
            busy       <= 1'b0;
            drop_pulse <= 1'b0;
        end else begin
            drop_pulse <= 1'b0;
            case (state)
                IDLE, WAIT_FILT: begin
                    if (in_fire) begin
                        if (in_type[1]) begin
                            drop_pulse <= 1'b1;
                        end else if (in_type[0]) begin
                            for (int i = 0; i < K; i++) w[i] <= in_data[i*WEIGHT_W +: WEIGHT_W];
                            filt_valid <= 1'b1;
                            if (state == WAIT_FILT) begin
                                state    <= MAC;
                                in_ready <= 1'b0;
                                j        <= '0;
                                k        <= '0;
                                acc      <= '0;
                            end
                        end else begin
                            spikes <= in_data[IFMAP_LEN-1:0];
                            j      <= '0;
                            k      <= '0;
                            acc    <= '0;
                            busy   <= 1'b1;
                            // An ifmap in WAIT_FILT just refreshes the spikes; filt_valid is never set there.
                            if (state == IDLE && filt_valid) begin
                                state    <= MAC;
                                in_ready <= 1'b0;
                            end else begin
                                state    <= WAIT_FILT;
                            end
                        end
                    end
                end
                MAC: begin
                    acc <= acc_sum;
                    if (k == K_W'(K-1)) begin
                        state     <= EMIT;
                        out_valid <= 1'b1;
                        out_data  <= make_pkt(ADDR_W'(PSUM_DST), 2'b11, psum_pl);
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                EMIT: begin
                    if (out_fire) begin
                        if (j != IDX_W'(N-1)) begin
                            state     <= MAC;
                            out_valid <= 1'b0;
                            j         <= j + 1'b1;
                            k         <= '0;
                            acc       <= '0;
                        end else if (FORWARD_EN != 0) begin
                            state    <= FWD;
                            out_data <= make_pkt(ADDR_W'(FWD_DST), 2'b00, fwd_pl);
                        end else begin
                            state     <= IDLE;
                            out_valid <= 1'b0;
                            busy      <= 1'b0;
                            in_ready  <= 1'b1;
                        end
                    end
                end
                FWD: begin
                    if (out_fire) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_spike_conv_pe.sv
// Bench for spike_conv_pe: directed scenarios plus randomized filters/ifmaps against a convolution reference model.
module tb_spike_conv_pe;
    localparam int K         = 5;
    localparam int IFMAP_LEN = 25;
    localparam int N         = IFMAP_LEN - K + 1;
    localparam int PSUM_DST  = 3;
    localparam int FWD_DST   = 5;
    localparam int SRC_ADDR  = 9;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        drop_pulse;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          t_acc    = 0;
    logic [7:0]  cur_w [K];

    spike_conv_pe #(
        .SRC_ADDR (SRC_ADDR),
        .PSUM_DST (PSUM_DST),
        .FWD_DST  (FWD_DST)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .drop_pulse (drop_pulse)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference: plain dot product of the filter with the window starting at j.
    function automatic int ref_psum(input logic [24:0] sp, input int j);
        int s = 0;
        for (int t = 0; t < K; t++)
            if (sp[j+t]) s += int'(cur_w[t]);
        return s;
    endfunction

    function automatic logic [63:0] psum_pkt(input int j, input int a);
        logic [63:0] p = '0;
        p[63:60] = 4'(PSUM_DST);
        p[59:56] = 4'(SRC_ADDR);
        p[55:54] = 2'b11;
        p[17:13] = 5'(j);
        p[12:0]  = 13'(a);
        return p;
    endfunction

    function automatic logic [63:0] fwd_pkt(input logic [24:0] sp);
        logic [63:0] p = '0;
        p[63:60] = 4'(FWD_DST);
        p[59:56] = 4'(SRC_ADDR);
        p[55:54] = 2'b00;
        p[24:0]  = sp;
        return p;
    endfunction

    function automatic logic [63:0] in_pkt(input logic [1:0] typ, input logic [53:0] pl);
        logic [63:0] p;
        p[63:56] = 8'($urandom);
        p[55:54] = typ;
        p[53:0]  = pl;
        return p;
    endfunction

    function automatic logic [63:0] filt_pkt();
        logic [53:0] pl;
        pl = {14'($urandom), 40'h0};
        for (int t = 0; t < K; t++) pl[t*8 +: 8] = cur_w[t];
        return in_pkt(2'b01, pl);
    endfunction

    function automatic logic [63:0] ifmap_pkt(input logic [24:0] sp);
        return in_pkt(2'b00, {29'($urandom), sp});
    endfunction

    task automatic send_pkt(input logic [63:0] p);
        int n = 0;
        in_data  = p;
        in_valid = 1'b1;
        while (!in_ready && n < 200) begin
            tick;
            n++;
        end
        if (!in_ready) begin
            check("in_ready_timeout", 64'(in_ready), 64'(1));
            in_valid = 1'b0;
            return;
        end
        tick;
        t_acc    = cyc;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output bit ok);
        int n = 0;
        while (!out_valid && n < 100) begin
            tick;
            n++;
        end
        ok = out_valid;
        if (!ok) check("out_valid_timeout", 64'(out_valid), 64'(1));
    endtask

    task automatic stall(input int n, input logic [63:0] exp);
        out_ready = 1'b0;
        repeat (n) begin
            tick;
            check("stall_valid", 64'(out_valid), 64'(1));
            check("stall_hold", out_data, exp);
        end
        out_ready = 1'b1;
    endtask

    task automatic expect_stream(input logic [24:0] sp, input int stall_idx, input bit rnd, input int t0);
        bit ok;
        int last = 0;
        bit prev_stalled = 1'b0;
        for (int j = 0; j <= N; j++) begin
            logic [63:0] exp;
            bit          st;
            exp = (j < N) ? psum_pkt(j, ref_psum(sp, j)) : fwd_pkt(sp);
            wait_valid(ok);
            if (!ok) return;
            if (j < N) check("psum", out_data, exp);
            else       check("fwd", out_data, exp);
            if (j == 0 && t0 >= 0) check("first_latency", 64'(cyc - t0 + 1), 64'(K + 1));
            if (j > 0 && j < N && !prev_stalled) check("psum_interval", 64'(cyc - last), 64'(K + 1));
            last = cyc;
            st = 1'b0;
            if (j == stall_idx) begin
                stall(10, exp);
                st = 1'b1;
            end else if (rnd && $urandom_range(0, 3) == 0) begin
                stall(int'($urandom_range(1, 4)), exp);
                st = 1'b1;
            end
            prev_stalled = st;
            tick;
        end
        check("idle_out_valid", 64'(out_valid), 64'(0));
        check("idle_busy", 64'(busy), 64'(0));
        check("idle_in_ready", 64'(in_ready), 64'(1));
    endtask

    initial begin
        logic [24:0] sp;
        logic [24:0] sp2;
        bit          ok;
        int          nv;

        rst = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b1;
        repeat (3) tick;
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_out_data", out_data, 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_drop", 64'(drop_pulse), 64'(0));
        rst = 1'b0;
        check("rst_in_ready", 64'(in_ready), 64'(1));

        // Residue packet in IDLE is discarded with a single drop pulse.
        send_pkt(in_pkt(2'b10, 54'($urandom)));
        check("drop_idle_pulse", 64'(drop_pulse), 64'(1));
        check("drop_idle_no_out", 64'(out_valid), 64'(0));
        tick;
        check("drop_idle_pulse_end", 64'(drop_pulse), 64'(0));
        check("drop_idle_busy", 64'(busy), 64'(0));

        for (int t = 0; t < K; t++) cur_w[t] = 8'd1;
        send_pkt(filt_pkt());
        check("filt_stays_idle", 64'(busy), 64'(0));
        send_pkt(ifmap_pkt(25'h1FFFFFF));
        expect_stream(25'h1FFFFFF, -1, 1'b0, t_acc);

        for (int t = 0; t < K; t++) cur_w[t] = 8'(t + 1);
        send_pkt(filt_pkt());
        send_pkt(ifmap_pkt(25'h0000001));
        expect_stream(25'h0000001, -1, 1'b0, t_acc);
        send_pkt(ifmap_pkt(25'h1000000));
        expect_stream(25'h1000000, -1, 1'b0, t_acc);

        // Ten-cycle backpressure in the middle of a stream.
        sp = 25'($urandom);
        send_pkt(ifmap_pkt(sp));
        expect_stream(sp, 4, 1'b0, t_acc);

        // Reset while output 7 is pending.
        sp = 25'($urandom);
        send_pkt(ifmap_pkt(sp));
        for (int j = 0; j <= 7; j++) begin
            wait_valid(ok);
            if (!ok) break;
            check("pre_rst_psum", out_data, psum_pkt(j, ref_psum(sp, j)));
            if (j < 7) tick;
        end
        rst = 1'b1;
        tick;
        check("midrst_out_valid", 64'(out_valid), 64'(0));
        check("midrst_busy", 64'(busy), 64'(0));
        check("midrst_out_data", out_data, 64'(0));
        rst = 1'b0;
        check("midrst_in_ready", 64'(in_ready), 64'(1));

        // Filter was cleared: ifmaps wait, a later ifmap replaces the first.
        sp = 25'($urandom);
        send_pkt(ifmap_pkt(sp));
        check("wait_busy", 64'(busy), 64'(1));
        check("wait_in_ready", 64'(in_ready), 64'(1));
        sp2 = 25'($urandom) | 25'h1;
        send_pkt(ifmap_pkt(sp2));
        send_pkt(in_pkt(2'b11, 54'($urandom)));
        check("drop_wait_pulse", 64'(drop_pulse), 64'(1));
        nv = 0;
        repeat (20) begin
            tick;
            if (out_valid) nv++;
        end
        check("wait_no_output", 64'(nv), 64'(0));
        check("wait_busy_hold", 64'(busy), 64'(1));
        for (int t = 0; t < K; t++) cur_w[t] = 8'($urandom);
        send_pkt(filt_pkt());
        expect_stream(sp2, -1, 1'b0, t_acc);

        for (int it = 0; it < 6; it++) begin
            for (int t = 0; t < K; t++) cur_w[t] = 8'($urandom);
            send_pkt(filt_pkt());
            sp = (it % 2 == 0) ? 25'($urandom) : 25'($urandom & $urandom);
            send_pkt(ifmap_pkt(sp));
            expect_stream(sp, -1, 1'b1, t_acc);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
